// File: rtl/bli201v32i_core_fetch.sv
// Purpose : BLI201V32I instruction fetch. Owns the PC, addresses the combinational
//           instruction TIM and queues {pc, inst} pairs in a 2-entry FIFO for decode.
// Latency : fetch-to-valid 1 cycle; a redirect's first instruction is valid 2 cycles later.
// Backpressure: valid/ready to decode. A full FIFO with no pop stalls the PC, and halt
//           stops new fetches while the FIFO keeps draining. Redirect flushes everything.
// Ports   : clk/rst (async, active-high); fetch_o_itim_addr/fetch_i_itim_rdata (TIM);
//           fetch_i_halt, fetch_i_redirect, fetch_i_target (control);
//           fetch_o_valid, fetch_o_pc, fetch_o_inst, fetch_i_ready (decode handshake).
module bli201v32i_core_fetch #(
    parameter int unsigned ROM_ADDR_BITS = 10,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ROM_ADDR_BITS+1:0] fetch_o_itim_addr,
    input  logic [31:0]              fetch_i_itim_rdata,
    input  logic                     fetch_i_halt,
    input  logic                     fetch_i_redirect,
    input  logic [31:0]              fetch_i_target,
    output logic                     fetch_o_valid,
    output logic [31:0]              fetch_o_pc,
    output logic [31:0]              fetch_o_inst,
    input  logic                     fetch_i_ready
);

    logic [31:0] r_pc;
    logic [31:0] r_ent_pc   [2];
    logic [31:0] r_ent_inst [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_count_nxt;
    logic [31:0] w_target;
    logic        w_unused_tgt;

    // Low target bits are forced to zero; the source guarantees alignment.
    assign w_target     = {fetch_i_target[31:2], 2'b00};
    assign w_unused_tgt = ^fetch_i_target[1:0];

    assign fetch_o_itim_addr = r_pc[ROM_ADDR_BITS+1:0];
    assign fetch_o_valid     = (r_count != 2'd0);

    // Head fields are masked while empty so stale entries never leak out,
    // which also makes the outputs read zero straight out of reset.
    assign fetch_o_pc   = fetch_o_valid ? r_ent_pc[r_rptr]   : 32'h0;
    assign fetch_o_inst = fetch_o_valid ? r_ent_inst[r_rptr] : 32'h0;

    assign w_pop = fetch_o_valid & fetch_i_ready;

    // A full FIFO may still accept a fetch when decode frees the head in the
    // same cycle, which is what sustains one instruction per cycle.
    assign w_push = ~fetch_i_redirect & ~fetch_i_halt & ((r_count != 2'd2) | w_pop);

    assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else if (fetch_i_redirect) begin
            // Flush wins over everything, including a coincident pop.
            r_pc    <= w_target;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc   <= r_pc + 32'd4;
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_nxt;
        end
    end

    // Entry storage needs no reset: it is only visible through fetch_o_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_pc[r_wptr]   <= r_pc;
            r_ent_inst[r_wptr] <= fetch_i_itim_rdata;
        end
    end

endmodule

// File: doc/bli201v32i_core_fetch.md
Name: bli201v32i_core_fetch

Overview:
- Instruction fetch stage of the BLI201V32I core. Sits directly upstream of the instruction TIM and directly downstream of the PC-redirect logic.
- Owns the program counter and drives the TIM byte address each cycle. The TIM read is combinational, so each fetched word is captured in the same cycle.
- Buffers fetched {pc, instruction} pairs in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (branch, jump, trap) and halt.

Parameters:
- ROM_ADDR_BITS, 10: TIM word-address width. The TIM address port is ROM_ADDR_BITS+2 bits wide (byte address).
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Must be word-aligned.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_o_itim_addr  output  ROM_ADDR_BITS+2  byte address to TIM; equals pc[ROM_ADDR_BITS+1:0].
- fetch_i_itim_rdata  input  32  instruction word from TIM (combinational from fetch_o_itim_addr).
- fetch_i_halt  input  1  when high, no new fetches are pushed; the PC holds.
- fetch_i_redirect  input  1  redirect request from execute/trap.
- fetch_i_target  input  32  redirect target; bits [1:0] ignored (treated as 0).
- fetch_o_valid  output  1  FIFO head is valid.
- fetch_o_pc  output  32  PC of the FIFO head.
- fetch_o_inst  output  32  instruction of the FIFO head.
- fetch_i_ready  input  1  decode accepts the head this cycle.

Behaviour:
- Reset, asynchronous:
  - pc = RESET_PC; FIFO count = 0; read/write pointers = 0.
  - fetch_o_valid = 0. fetch_o_pc and fetch_o_inst = 0.
  - Reset asserted mid-operation discards all buffered entries immediately.
- State:
  - 32-bit pc.
  - 2-entry FIFO of {pc, inst}.
  - 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- pop = fetch_o_valid & fetch_i_ready.
- push = !fetch_i_redirect & !fetch_i_halt & (count < 2 | pop).
  - A push when the FIFO is full is allowed only with a same-cycle pop (pass-through of the freed slot). Count then stays 2.
- On push:
  - The entry {pc, fetch_i_itim_rdata} is written at the write pointer.
  - pc <= pc + 4, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
  - fetch_o_itim_addr wraps naturally within ROM_ADDR_BITS+2 bits.
- Count update: count <= count + push - pop.
- Redirect has priority over push, pop and halt:
  - Next cycle: pc = {fetch_i_target[31:2], 2'b00}, count = 0, pointers = 0, fetch_o_valid = 0.
  - A pop coinciding with redirect still counts as a handshake to decode, but the entry is discarded internally with the flush.
  - The first post-redirect instruction appears on fetch_o_valid 2 cycles after the redirect cycle:
    - Cycle R+1: fetch at target, push.
    - Cycle R+2: valid.
- Output timing:
  - fetch_o_valid = (count != 0). fetch_o_pc and fetch_o_inst come from the head entry.
  - Outputs are stable while fetch_o_valid & !fetch_i_ready, i.e. held until accepted.
  - Fetch-to-valid latency is 1 cycle.
  - Steady-state throughput is 1 instruction/cycle with fetch_i_ready held high.
- Halt:
  - PC and pushes freeze; pops continue, so the FIFO drains.
  - Deasserting halt resumes fetching at the held pc.
- Empty FIFO: fetch_o_valid = 0; fetch_i_ready is ignored.
- Full FIFO, no pop: no push; pc holds; fetch_o_itim_addr is unchanged.
- Out of scope: no misalignment exception and no bus error. Target alignment is the redirect source's responsibility.

Test Plan:
- Reset release, RESET_PC = 0, ready = 1, TIM preloaded mem[i] = 32'h1000_0000+i:
  - Cycle 1 after reset: valid = 1, pc = 0, inst = 32'h1000_0000.
  - Then pc 4, 8, 12 on consecutive cycles with no bubbles.
- ready = 0 from reset:
  - Two pushes (pc 0 and 4), then count = 2, fetch_o_itim_addr holds 8, head stays pc = 0.
  - Raise ready: pcs delivered 0, 4, 8 on consecutive cycles.
- Redirect with target 32'h0000_0103 while FIFO is full:
  - Next cycle: valid = 0.
  - Following cycle: valid = 1, pc = 32'h100, inst = mem[64].
  - No stale pc 0/4 delivered afterwards.
- Halt for 5 cycles with ready = 1:
  - FIFO drains to valid = 0; addr frozen.
  - On release, fetch resumes at the frozen pc with no skip or duplicate.
- Redirect to 32'hFFFF_FFFC:
  - Sequence delivers pc FFFF_FFFC then 0000_0000.
  - fetch_o_itim_addr wraps 12'hFFC to 0 (ROM_ADDR_BITS = 10).
- Assert rst asynchronously mid-stream with count = 2:
  - valid drops immediately without a clock edge.
  - After release, first delivered pc = RESET_PC.
